// File: rtl/game_sequencer.sv
// Starflux frame sequencer: frame divider, per-frame strobes
// (ship, grid, draw), lives/game-over and frame statistics.
//
// Ports:
//   clk, reset          50 MHz clock, sync active-high reset
//   start, pause        level controls
//   hit, draw_done      one-cycle pulses in
//   ship_update_en      one-cycle strobe to datapath
//   grid_update_en      one-cycle strobe to datapath
//   draw_start          one-cycle strobe to renderer
//   game_active         high in WAIT..CHECK
//   game_over           high in OVER
//   lives [2:0]         remaining lives
//   frame_count [15:0]  completed frames (wraps)
//   overrun_cnt [7:0]   ticks missed while busy (saturates)
//   draw_timeout_err    sticky DRAW timeout flag
module game_sequencer #(
  parameter int TICKS_PER_FRAME = 833333,
  parameter int TICK_W          = 20,
  parameter int START_LIVES     = 3,
  parameter int DRAW_TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        hit,
  input  logic        draw_done,
  output logic        ship_update_en,
  output logic        grid_update_en,
  output logic        draw_start,
  output logic        game_active,
  output logic        game_over,
  output logic [2:0]  lives,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_cnt,
  output logic        draw_timeout_err
);

  localparam int TO_W = $clog2(DRAW_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SHIP, S_GRID,
    S_DRAW, S_CHECK, S_OVER
  } state_t;

  state_t state, state_nx;

  logic [TICK_W-1:0] div_q;
  logic [TO_W-1:0]   to_q;
  logic              pend_q;
  logic              hit_q;
  logic              running;
  logic              tick;
  logic              go;
  logic              load;
  logic              to_hit;
  logic [2:0]        lives_dec;

  assign running = (state != S_IDLE) &&
                   (state != S_OVER);
  assign tick = running &&
    (div_q == TICK_W'(TICKS_PER_FRAME - 1));
  assign go = (state == S_WAIT) &&
              (pend_q || tick) && !pause;
  assign load = start &&
    ((state == S_IDLE) || (state == S_OVER));
  assign to_hit = (to_q == TO_W'(DRAW_TIMEOUT - 1));
  assign lives_dec = (hit_q && lives != 3'd0) ?
                     lives - 3'd1 : lives;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_WAIT;
      S_WAIT:  if (go) state_nx = S_SHIP;
      S_SHIP:  state_nx = S_GRID;
      S_GRID:  state_nx = S_DRAW;
      S_DRAW:
        if (draw_done || to_hit)
          state_nx = S_CHECK;
      S_CHECK:
        state_nx = (lives_dec == 3'd0) ?
                   S_OVER : S_WAIT;
      S_OVER:  if (start) state_nx = S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ship_update_en = 1'b0;
    grid_update_en = 1'b0;
    draw_start     = 1'b0;
    game_active    = running;
    game_over      = (state == S_OVER);
    unique case (state)
      S_SHIP:  ship_update_en = 1'b1;
      S_GRID:  grid_update_en = 1'b1;
      // only the entry cycle of DRAW has a zero count
      S_DRAW:  draw_start = (to_q == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q            <= '0;
      to_q             <= '0;
      pend_q           <= 1'b0;
      hit_q            <= 1'b0;
      lives            <= '0;
      frame_count      <= '0;
      overrun_cnt      <= '0;
      draw_timeout_err <= 1'b0;
    end else begin
      if (!running || tick) div_q <= '0;
      else div_q <= div_q + TICK_W'(1);

      if (state == S_DRAW) to_q <= to_q + TO_W'(1);
      else to_q <= '0;

      // a pending tick consumed by go makes room
      // for a tick arriving in the same cycle
      if (!running) pend_q <= 1'b0;
      else if (go) pend_q <= pend_q && tick;
      else if (tick) pend_q <= 1'b1;

      if (load) overrun_cnt <= '0;
      else if (tick && pend_q && !go &&
               overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      // a hit during CHECK belongs to the next frame
      if (!running) hit_q <= 1'b0;
      else if (state == S_CHECK) hit_q <= hit;
      else hit_q <= hit_q || hit;

      if (load) lives <= 3'(START_LIVES);
      else if (state == S_CHECK) lives <= lives_dec;

      if (load) frame_count <= '0;
      else if (state == S_CHECK)
        frame_count <= frame_count + 16'd1;

      if (load) draw_timeout_err <= 1'b0;
      else if (state == S_DRAW && !draw_done && to_hit)
        draw_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: frame timing, lives,
// restart, overrun, draw timeout and reset/pause behaviour.
module tb_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic hit = 1'b0;
  logic draw_done = 1'b0;

  logic ship, grid, draw, active, over, err;
  logic [2:0] lives;
  logic [15:0] frame;
  logic [7:0] ovr;

  logic t_ship, t_grid, t_draw, t_active, t_over, t_err;
  logic [2:0] t_lives;
  logic [15:0] t_frame;
  logic [7:0] t_ovr;

  int pass_cnt = 0;
  int total_cnt = 0;

  game_sequencer #(
    .TICKS_PER_FRAME(16), .TICK_W(8),
    .START_LIVES(3), .DRAW_TIMEOUT(1000)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .pause(pause), .hit(hit), .draw_done(draw_done),
    .ship_update_en(ship), .grid_update_en(grid),
    .draw_start(draw), .game_active(active),
    .game_over(over), .lives(lives),
    .frame_count(frame), .overrun_cnt(ovr),
    .draw_timeout_err(err)
  );

  game_sequencer #(
    .TICKS_PER_FRAME(16), .TICK_W(8),
    .START_LIVES(3), .DRAW_TIMEOUT(10)
  ) u_dut_to (
    .clk(clk), .reset(reset), .start(start),
    .pause(pause), .hit(hit), .draw_done(draw_done),
    .ship_update_en(t_ship), .grid_update_en(t_grid),
    .draw_start(t_draw), .game_active(t_active),
    .game_over(t_over), .lives(t_lives),
    .frame_count(t_frame), .overrun_cnt(t_ovr),
    .draw_timeout_err(t_err)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_game();
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    hit = 1'b0; draw_done = 1'b0;
    step(2);
    reset = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  function automatic logic strobe_of(input int which);
    case (which)
      0: return ship;
      1: return grid;
      2: return draw;
      3: return t_draw;
      default: return t_ship;
    endcase
  endfunction

  task automatic wait_strobe(input int which,
                             input int budget,
                             output int cyc);
    int i;
    i = 0;
    cyc = -1;
    while (cyc < 0 && i < budget) begin
      step(1);
      i++;
      if (strobe_of(which)) cyc = i;
    end
  endtask

  task automatic finish_frame(output int cyc);
    wait_strobe(2, 40, cyc);
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    total_cnt++;
    if ({ship, grid, draw, active, over} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {ship, grid, draw, active, over});
    else pass_cnt++;
    total_cnt++;
    if (lives !== 3'd0)
      $display("FAIL reset_lives got %0d want 0", lives);
    else pass_cnt++;
    total_cnt++;
    if (frame !== 16'd0 || ovr !== 8'd0 || err !== 1'b0)
      $display("FAIL reset_stats got %0d/%0d/%b want 0/0/0",
               frame, ovr, err);
    else pass_cnt++;
    reset = 1'b0;
    step(3);
    total_cnt++;
    if ({active, ship} !== 2'b00)
      $display("FAIL idle_hold got %b want 00", {active, ship});
    else pass_cnt++;
  endtask

  task automatic test_frame_timing();
    logic [2:0] exp;
    logic [15:0] fexp;
    start_game();
    total_cnt++;
    if (active !== 1'b1 || lives !== 3'd3)
      $display("FAIL start_load got %b/%0d want 1/3",
               active, lives);
    else pass_cnt++;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      draw_done = (k == 22 || k == 38);
      case (k)
        16, 32:  exp = 3'b100;
        17, 33:  exp = 3'b010;
        18, 34:  exp = 3'b001;
        default: exp = 3'b000;
      endcase
      total_cnt++;
      if ({ship, grid, draw} !== exp)
        $display("FAIL strobes_c%0d got %b want %b",
                 k, {ship, grid, draw}, exp);
      else pass_cnt++;
      if (k == 23 || k == 24 || k == 39 || k == 40) begin
        fexp = (k < 24) ? 16'd0 : (k < 40) ? 16'd1 : 16'd2;
        total_cnt++;
        if (frame !== fexp)
          $display("FAIL frame_c%0d got %0d want %0d",
                   k, frame, fexp);
        else pass_cnt++;
      end
    end
    draw_done = 1'b0;
  endtask

  task automatic test_hits();
    int cyc;
    int nstr;
    start_game();
    step(2);
    repeat (3) begin
      hit = 1'b1; step(1);
      hit = 1'b0; step(1);
    end
    finish_frame(cyc);
    total_cnt++;
    if (cyc == -1 || lives !== 3'd2 || active !== 1'b1)
      $display("FAIL multi_hit got c%0d l%0d a%b want l2 a1",
               cyc, lives, active);
    else pass_cnt++;
    hit = 1'b1; step(1); hit = 1'b0;
    finish_frame(cyc);
    total_cnt++;
    if (cyc == -1 || lives !== 3'd1)
      $display("FAIL hit_f2 got c%0d l%0d want l1", cyc, lives);
    else pass_cnt++;
    hit = 1'b1; step(1); hit = 1'b0;
    finish_frame(cyc);
    total_cnt++;
    if (cyc == -1 || lives !== 3'd0 ||
        over !== 1'b1 || active !== 1'b0)
      $display("FAIL game_over got l%0d o%b a%b want l0 o1 a0",
               lives, over, active);
    else pass_cnt++;
    nstr = 0;
    for (int i = 0; i < 40; i++) begin
      hit = (i == 5);
      step(1);
      nstr += int'(ship) + int'(grid) + int'(draw);
    end
    hit = 1'b0;
    total_cnt++;
    if (nstr != 0 || lives !== 3'd0)
      $display("FAIL over_quiet got n%0d l%0d want n0 l0",
               nstr, lives);
    else pass_cnt++;
  endtask

  task automatic test_over_restart();
    int cyc;
    start = 1'b1; hit = 1'b1;
    step(1);
    start = 1'b0; hit = 1'b0;
    total_cnt++;
    if (lives !== 3'd3 || active !== 1'b1 || over !== 1'b0)
      $display("FAIL restart got l%0d a%b o%b want l3 a1 o0",
               lives, active, over);
    else pass_cnt++;
    total_cnt++;
    if (frame !== 16'd0 || err !== 1'b0 || ovr !== 8'd0)
      $display("FAIL restart_clr got %0d/%b/%0d want 0/0/0",
               frame, err, ovr);
    else pass_cnt++;
    finish_frame(cyc);
    total_cnt++;
    if (cyc == -1 || lives !== 3'd3 || frame !== 16'd1)
      $display("FAIL restart_hit got c%0d l%0d f%0d want l3 f1",
               cyc, lives, frame);
    else pass_cnt++;
  endtask

  task automatic test_hit_in_check();
    int cyc;
    start_game();
    wait_strobe(2, 40, cyc);
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    total_cnt++;
    if (cyc == -1 || lives !== 3'd3 || frame !== 16'd1)
      $display("FAIL check_hit got l%0d f%0d want l3 f1",
               lives, frame);
    else pass_cnt++;
    finish_frame(cyc);
    total_cnt++;
    if (cyc == -1 || lives !== 3'd2)
      $display("FAIL check_hit_next got l%0d want 2", lives);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int cyc;
    start_game();
    wait_strobe(2, 40, cyc);
    total_cnt++;
    if (cyc !== 18)
      $display("FAIL draw_lat got %0d want 18", cyc);
    else pass_cnt++;
    step(47);
    draw_done = 1'b1;
    step(1);
    draw_done = 1'b0;
    total_cnt++;
    if (ovr !== 8'd2 || err !== 1'b0)
      $display("FAIL overrun got %0d/%b want 2/0", ovr, err);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ship !== 1'b0 || frame !== 16'd1)
      $display("FAIL ovr_check got s%b f%0d want s0 f1",
               ship, frame);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (ship !== 1'b1)
      $display("FAIL pending_ship got %b want 1", ship);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int cyc;
    start_game();
    wait_strobe(3, 40, cyc);
    total_cnt++;
    if (cyc !== 18)
      $display("FAIL to_draw got %0d want 18", cyc);
    else pass_cnt++;
    step(9);
    total_cnt++;
    if (t_err !== 1'b0 || t_active !== 1'b1)
      $display("FAIL to_early got e%b a%b want e0 a1",
               t_err, t_active);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (t_err !== 1'b1)
      $display("FAIL to_set got %b want 1", t_err);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (t_frame !== 16'd1 || t_lives !== 3'd3 || t_over !== 1'b0)
      $display("FAIL to_check got f%0d l%0d o%b want f1 l3 o0",
               t_frame, t_lives, t_over);
    else pass_cnt++;
    wait_strobe(4, 20, cyc);
    total_cnt++;
    if (cyc !== 3 || {t_ship, t_grid, t_draw} !== 3'b100)
      $display("FAIL to_next got c%0d s%b want c3 s100",
               cyc, {t_ship, t_grid, t_draw});
    else pass_cnt++;
    total_cnt++;
    if (t_err !== 1'b1 || t_ovr !== 8'd0)
      $display("FAIL to_sticky got e%b o%0d want e1 o0",
               t_err, t_ovr);
    else pass_cnt++;
  endtask

  task automatic test_reset_grid_pause();
    int cyc;
    int nship;
    start_game();
    wait_strobe(1, 40, cyc);
    reset = 1'b1;
    step(1);
    total_cnt++;
    if (cyc == -1 ||
        {ship, grid, draw, active, over, lives,
         frame, ovr, err} !== 33'd0)
      $display("FAIL mid_reset got c%0d %h want 0", cyc,
               {ship, grid, draw, active, over, lives,
                frame, ovr, err});
    else pass_cnt++;
    reset = 1'b0; pause = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    total_cnt++;
    if (active !== 1'b1)
      $display("FAIL pause_start got %b want 1", active);
    else pass_cnt++;
    nship = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      nship += int'(ship);
    end
    total_cnt++;
    if (nship != 0 || ovr !== 8'd0)
      $display("FAIL pause_hold got n%0d o%0d want n0 o0",
               nship, ovr);
    else pass_cnt++;
    pause = 1'b0;
    step(1);
    total_cnt++;
    if (ship !== 1'b1)
      $display("FAIL unpause_ship got %b want 1", ship);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_hits();
    test_over_restart();
    test_hit_in_check();
    test_overrun();
    test_timeout();
    test_reset_grid_pause();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
